// File: rtl/life_pkg.sv
// Shared widths and limits for the Game of Life control blocks.
package life_pkg;

  localparam int unsigned STEP_W = 21;  // tick counter / period width
  localparam int unsigned LVL_W  = 3;   // speed level width

  localparam logic [LVL_W-1:0] LVL_MAX = 3'd7;

endpackage : life_pkg

// File: rtl/rise_edge.sv
// Rising-edge detector for an already synchronous, debounced level input.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-low reset (prev flop cleared)
//   in    - level input
//   pulse - combinational one-cycle pulse on a 0->1 transition of in
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  // Previous-sample flop; cleared so a held input after reset yields an edge
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule : rise_edge

// File: rtl/envolve_v_ctrl.sv
// Evolution-speed controller: emits a one-clock envolve_v tick every
// P = PERIOD_MAX >> lvl clocks while mode is high; lvl is stepped by
// edge-detected faster/slower buttons.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-low reset
//   mode      - 1 = auto-evolve, 0 = paused
//   inc_v     - faster button (level, debounced)
//   dec_v     - slower button (level, debounced)
//   envolve_v - registered evolve tick, one clock wide
//   test_p1   - current tick period P in clocks
module envolve_v_ctrl
  import life_pkg::*;
#(
  parameter int unsigned PERIOD_MAX  = 2_000_000,
  parameter int unsigned RESET_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              inc_v,
  input  logic              dec_v,
  output logic              envolve_v,
  output logic [STEP_W-1:0] test_p1
);

  logic              inc_p;
  logic              dec_p;
  logic              lvl_up;
  logic              lvl_dn;
  logic              lvl_chg;
  logic [LVL_W-1:0]  lvl_q,  lvl_d;
  logic [STEP_W-1:0] cnt_q,  cnt_d;
  logic              env_q,  env_d;
  logic [STEP_W-1:0] period;

  rise_edge u_inc_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (inc_v),
    .pulse (inc_p)
  );

  rise_edge u_dec_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (dec_v),
    .pulse (dec_p)
  );

  // Only non-saturated, non-conflicting presses count as a level change
  assign lvl_up  = inc_p & ~dec_p & (lvl_q != LVL_MAX);
  assign lvl_dn  = dec_p & ~inc_p & (lvl_q != '0);
  assign lvl_chg = lvl_up | lvl_dn;

  assign period = STEP_W'(PERIOD_MAX) >> lvl_q;

  // Next level, counter and tick; a level change outranks pause and terminal count
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q + STEP_W'(1);
    env_d = 1'b0;
    if (lvl_up)      lvl_d = lvl_q + LVL_W'(1);
    else if (lvl_dn) lvl_d = lvl_q - LVL_W'(1);

    if (lvl_chg || !mode) begin
      cnt_d = '0;
    end else if (cnt_q == period - STEP_W'(1)) begin
      cnt_d = '0;
      env_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q <= LVL_W'(RESET_LEVEL);
      cnt_q <= '0;
      env_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      env_q <= env_d;
    end
  end

  assign envolve_v = env_q;
  assign test_p1   = period;

endmodule : envolve_v_ctrl

// File: tb/tb_envolve_v_ctrl.sv
// Self-checking bench for envolve_v_ctrl with a cycle-level reference model.
module tb_envolve_v_ctrl;

  localparam int unsigned PMAX = 128;
  localparam int unsigned RL   = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        mode  = 1'b0;
  logic        inc_v = 1'b0;
  logic        dec_v = 1'b0;
  logic        envolve_v;
  logic [20:0] test_p1;

  always #20 clk = ~clk;

  envolve_v_ctrl #(.PERIOD_MAX(PMAX), .RESET_LEVEL(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .inc_v     (inc_v),
    .dec_v     (dec_v),
    .envolve_v (envolve_v),
    .test_p1   (test_p1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: level, previous button samples, run edges since restart
  int m_lvl   = RL;
  bit m_pi    = 1'b0;
  bit m_pd    = 1'b0;
  int m_phase = 0;
  bit m_env   = 1'b0;

  function automatic int per_of(input int lvl);
    return int'(PMAX) / (1 << lvl);
  endfunction

  task automatic model(input bit r, input bit m, input bit i, input bit d);
    bit ie, de;
    int nl;
    if (!r) begin
      m_lvl = RL; m_pi = 0; m_pd = 0; m_phase = 0; m_env = 0;
    end else begin
      ie = i && !m_pi;
      de = d && !m_pd;
      m_pi = i;
      m_pd = d;
      nl = m_lvl;
      if (ie && !de)      nl = (m_lvl < 7) ? m_lvl + 1 : 7;
      else if (de && !ie) nl = (m_lvl > 0) ? m_lvl - 1 : 0;
      if (nl != m_lvl) begin
        m_lvl = nl; m_phase = 0; m_env = 0;
      end else if (!m) begin
        m_phase = 0; m_env = 0;
      end else begin
        m_phase++;
        m_env = (m_phase % per_of(m_lvl)) == 0;
      end
    end
  endtask

  // Apply inputs, advance one clock, update model, compare outputs
  task automatic step(input bit r, input bit m, input bit i, input bit d);
    rst = r; mode = m; inc_v = i; dec_v = d;
    @(posedge clk);
    #1;
    model(r, m, i, d);
    total++;
    assert (envolve_v === m_env) else begin
      bad++;
      $error("FAIL envolve_v: got %b expected %b (lvl %0d phase %0d)", envolve_v, m_env, m_lvl, m_phase);
    end
    total++;
    assert (test_p1 === 21'(per_of(m_lvl))) else begin
      bad++;
      $error("FAIL test_p1_model: got %0d expected %0d", test_p1, per_of(m_lvl));
    end
  endtask

  task automatic chk_p(input int exp, input string tag);
    total++;
    assert (test_p1 === 21'(exp)) else begin
      bad++;
      $error("FAIL %s: test_p1 got %0d expected %0d", tag, test_p1, exp);
    end
  endtask

  task automatic press(input bit m, input bit inc);
    step(1, m, inc, !inc);
    step(1, m, 0, 0);
  endtask

  initial begin
    bit rm, ri, rd, rr;
    int gap;
    bit seen;

    // Reset
    repeat (3) step(0, 0, 0, 0);
    chk_p(32, "reset_period");
    total++;
    assert (envolve_v === 1'b0) else begin
      bad++;
      $error("FAIL reset_env: got %b expected 0", envolve_v);
    end

    // Auto run then pause
    repeat (100) step(1, 1, 0, 0);
    repeat (40) step(1, 0, 0, 0);

    // Held inc, then held dec
    step(1, 0, 1, 0);
    chk_p(16, "held_inc_first");
    repeat (24) step(1, 0, 1, 0);
    chk_p(16, "held_inc_norepeat");
    step(1, 0, 0, 0);
    repeat (25) step(1, 0, 0, 1);
    chk_p(32, "held_dec");
    step(1, 0, 0, 0);

    // Saturate fast
    repeat (7) press(1, 1);
    chk_p(1, "sat_fast");
    repeat (10) begin
      step(1, 1, 0, 0);
      total++;
      assert (envolve_v === 1'b1) else begin
        bad++;
        $error("FAIL p1_continuous: got %b expected 1", envolve_v);
      end
    end
    press(1, 1);
    chk_p(1, "sat_fast_extra");

    // Saturate slow
    repeat (7) press(1, 0);
    chk_p(128, "sat_slow");
    press(1, 0);
    chk_p(128, "sat_slow_extra");

    // Simultaneous presses: no change, no restart
    repeat (50) step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk_p(128, "simultaneous");
    repeat (150) step(1, 1, 0, 0);

    // Change mid-count: restart, next pulse 64 clocks later
    step(1, 0, 0, 0);
    repeat (100) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk_p(64, "midcount_inc");
    gap = 0;
    seen = 0;
    while (!seen && gap < 200) begin
      step(1, 1, 0, 0);
      gap++;
      seen = envolve_v;
    end
    total++;
    assert (gap === 64) else begin
      bad++;
      $error("FAIL midcount_gap: got %0d expected 64", gap);
    end

    // Randomized traffic against the model
    rm = 1; ri = 0; rd = 0;
    for (int n = 0; n < 4000; n++) begin
      rr = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) rm = ~rm;
      if ($urandom_range(0, 9) == 0)  ri = ~ri;
      if ($urandom_range(0, 9) == 0)  rd = ~rd;
      step(rr, rm, ri, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_envolve_v_ctrl

// File: doc/envolve_v_ctrl.md
# envolve_v_ctrl

Evolution-speed controller for the Game of Life core. It produces a single-cycle `envolve_v` tick that advances the board one generation, at one of eight user-selectable rates. Rate changes come from the faster/slower buttons `inc_v`/`dec_v`. The block sits between the debounced button logic and the board-update engine, and exports the active tick period on `test_p1` for debug and display.

## Interface
Parameters:
- `PERIOD_MAX`, default 2_000_000: tick period in clocks at the slowest level 0. It must satisfy `PERIOD_MAX >> 7 >= 1` and must fit in 21 bits.
- `RESET_LEVEL`, default 2: speed level loaded on reset (0..7).

Ports:
- `clk` input, 1 bit: single system clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-low.
- `mode` input, 1 bit: 1 = auto-evolve (ticks run); 0 = paused/manual (no ticks).
- `inc_v` input, 1 bit: faster request, level-held button, already synchronous and debounced.
- `dec_v` input, 1 bit: slower request, same conditioning as `inc_v`.
- `envolve_v` output, 1 bit: registered evolve tick, one clock wide.
- `test_p1` output, 21 bits: current tick period P in clocks, unsigned.

## Operation
- Speed level `lvl` is 3 bits, range 0..7. Period `P = PERIOD_MAX >> lvl`. Level 0 is slowest; level 7 is fastest.
- Edge detect:
  - `inc_v` and `dec_v` are each registered into a `prev` flop.
  - A press is the rising edge `x & ~prev_x`.
  - Holding a button does not repeat; one press changes the level by at most one step.
- Level update:
  - An inc edge alone sets `lvl <= min(lvl+1, 7)`.
  - A dec edge alone sets `lvl <= max(lvl-1, 0)`.
  - Both edges in the same cycle leave `lvl` unchanged.
  - Saturated requests (inc at 7, dec at 0) are ignored and do not restart the counter.
  - Level changes are accepted in both modes.
- Tick counter `cnt` is 21 bits. Each clock, in priority order:
  1. Reset: `cnt <= 0`, `envolve_v <= 0`, `lvl <= RESET_LEVEL`, both `prev` flops `<= 0`.
  2. Effective level change: `cnt <= 0`, `envolve_v <= 0`.
  3. `mode == 0`: `cnt <= 0`, `envolve_v <= 0`.
  4. `cnt == P-1`: `cnt <= 0`, `envolve_v <= 1`.
  5. Otherwise: `cnt <= cnt+1`, `envolve_v <= 0`.
- `test_p1 = P`, zero-extended, derived from the registered `lvl`.

## Timing
- Reset values: `envolve_v = 0`, `test_p1 = PERIOD_MAX >> RESET_LEVEL`.
- Button latency: a button rising at clock edge n−1 is sampled at edge n; `lvl` and `test_p1` update at edge n.
- A button already high when reset releases produces an edge on the first post-reset cycle, because `prev` resets to 0.
- Tick cadence:
  - After `mode` goes high (or after a counter restart), the first `envolve_v` pulse is high for the cycle following the P-th sampling edge.
  - Pulses then repeat every P clocks, each exactly one clock wide.
  - P = 1 holds `envolve_v` high continuously while `mode = 1`.
- Pause: dropping `mode` to 0 forces `envolve_v` low from the next edge and discards the partial count.
- A reset asserted mid-count overrides everything on that edge.

## Structure
- Shared package `life_pkg`:
  - `STEP_W = 21`
  - `LVL_W = 3`
  - `LVL_MAX = 3'd7`
- Sub-module `rise_edge` (clk, rst, in → pulse), instantiated once for `inc_v` and once for `dec_v`.
- The level register, period shifter and tick counter live in the top module.

## Test plan
All scenarios use `PERIOD_MAX = 128`, `RESET_LEVEL = 2`, and a 40 ns clock.
- Reset: hold `rst = 0` for 3 clocks -> `envolve_v = 0`, `test_p1 = 32`.
- Auto run: `mode = 1`, no buttons -> first pulse 32 clocks after `mode` is sampled high, then a pulse every 32 clocks, each 1 clock wide; `mode = 0` -> no further pulses.
- Held inc: `inc_v = 1` for 25 clocks -> `test_p1` becomes 16 one cycle after the press and stays 16 (no auto-repeat). Then `dec_v = 1` for 25 clocks -> `test_p1 = 32`.
- Saturation:
  - 7 separate inc presses -> `test_p1 = 1`, and `envolve_v` is continuously high with `mode = 1`; an 8th press leaves it at 1.
  - 7 dec presses -> `test_p1 = 128`; a further press leaves it at 128.
- Simultaneous: `inc_v` and `dec_v` rise on the same clock -> `test_p1` unchanged and the counter is not restarted.
- Change mid-count: at level 0, with `cnt` near 100, press inc -> counter restarts and the next pulse comes 64 clocks after the level change.
